// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory bus responder: default window bases,
// MMIO register byte offsets, STATUS bit positions, the MTIMECMP reset value,
// and a byte-lane merge helper used by the byte-enabled MMIO registers.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h2000_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

    // Byte offsets inside the 4 KiB MMIO window (word aligned).
    localparam logic [11:0] OFF_MTIME_LO    = 12'h000;
    localparam logic [11:0] OFF_MTIME_HI    = 12'h004;
    localparam logic [11:0] OFF_MTIMECMP_LO = 12'h008;
    localparam logic [11:0] OFF_MTIMECMP_HI = 12'h00C;
    localparam logic [11:0] OFF_STATUS      = 12'h010;
    localparam logic [11:0] OFF_GPIO        = 12'h014;
    localparam logic [11:0] OFF_ERRADDR     = 12'h018;

    localparam int STATUS_IRQ_BIT = 0;
    localparam int STATUS_ERR_BIT = 1;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lane_en
    );
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// -----------------------------------------------------------------------------
// dmem_timer
// 64-bit free-running machine timer with compare register, a HI-word shadow
// latched on MTIME_LO reads, and a sticky interrupt-pending flag.
// Only instantiated when DMEM_TIMER_EN is defined.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_lo_read           MTIME_LO is being read this cycle (no store)
//   i_cmp_lo_we/hi_we   store strobes for MTIMECMP_LO / MTIMECMP_HI
//   i_irq_clr           write-1 to STATUS irq bit this cycle
//   i_wdata, i_be       store data and byte-lane enables
//   o_mtime_lo          live low word of mtime
//   o_mtime_hi_shadow   HI word captured at the last MTIME_LO read
//   o_mtimecmp          compare register
//   o_irq               interrupt pending (registered)
// -----------------------------------------------------------------------------
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_lo_read,
    input  logic        i_cmp_lo_we,
    input  logic        i_cmp_hi_we,
    input  logic        i_irq_clr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic [31:0] o_mtime_lo,
    output logic [31:0] o_mtime_hi_shadow,
    output logic [63:0] o_mtimecmp,
    output logic        o_irq
);

    logic [63:0] r_mtime;
    logic [31:0] r_mtime_hi_shadow;
    logic [63:0] r_mtimecmp;
    logic        r_pending;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime           <= 64'h0;
            r_mtime_hi_shadow <= 32'h0;
            r_mtimecmp        <= MTIMECMP_RESET;
            r_pending         <= 1'b0;
        end else begin
            r_mtime <= r_mtime + 64'd1;

            // Software reads LO then HI; HI must belong to the same instant.
            if (i_lo_read) begin
                r_mtime_hi_shadow <= r_mtime[63:32];
            end

            if (i_cmp_lo_we) begin
                r_mtimecmp[31:0] <= merge_lanes(r_mtimecmp[31:0], i_wdata, i_be);
            end
            if (i_cmp_hi_we) begin
                r_mtimecmp[63:32] <= merge_lanes(r_mtimecmp[63:32], i_wdata, i_be);
            end

            // Clear wins over a same-cycle set; a still-true compare sets the
            // flag again on the following edge.
            if (i_irq_clr) begin
                r_pending <= 1'b0;
            end else if (r_mtime >= r_mtimecmp) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_mtime_lo        = r_mtime[31:0];
    assign o_mtime_hi_shadow = r_mtime_hi_shadow;
    assign o_mtimecmp        = r_mtimecmp;
    assign o_irq             = r_pending;

endmodule

// File: rtl/dmem_bus_responder.sv
// -----------------------------------------------------------------------------
// dmem_bus_responder
// Data-side bus slave for a simple core: a byte-writable RAM window, a 4 KiB
// MMIO register window (timer, STATUS, GPIO, ERRADDR) and a sticky error flag
// for stores to unmapped addresses. Loads are combinational; stores commit on
// the rising edge.
//
// Build option: define DMEM_TIMER_EN to include the machine timer
// (MTIME/MTIMECMP registers, STATUS irq bit, timer_irq). Without it those
// registers read 0, ignore writes, and timer_irq is tied low.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   MemWrite     store strobe
//   ALUResult    byte address (bits [1:0] ignored for decode)
//   WriteData    lane-aligned store data
//   byte_enable  store lane mask, bit i covers WriteData[8i+7:8i]
//   ReadData     combinational load data
//   timer_irq    registered timer interrupt level
//   gpio_out     registered GPIO register
//   bus_err      sticky unmapped-store flag
// -----------------------------------------------------------------------------
module dmem_bus_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] RAM_BASE    = RAM_BASE_DEFAULT,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  byte_enable,
    output logic [31:0] ReadData,
    output logic        timer_irq,
    output logic [7:0]  gpio_out,
    output logic        bus_err
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    // ---------------------------------------------------------------- decode
    logic [31:0]      w_word_addr;
    logic [31:0]      w_ram_off;
    logic             w_ram_hit;
    logic [IDX_W-1:0] w_ram_idx;
    logic             w_mmio_hit;
    logic [11:0]      w_mmio_off;
    logic             w_mmio_wr;
    logic             w_err_store;
    logic             w_err_clr;

    assign w_word_addr = {ALUResult[31:2], 2'b00};
    // Addresses below RAM_BASE wrap to huge offsets, so one compare covers
    // both window edges.
    assign w_ram_off   = w_word_addr - RAM_BASE;
    assign w_ram_hit   = ({1'b0, w_ram_off} < RAM_BYTES);
    assign w_ram_idx   = w_ram_off[IDX_W+1:2];
    assign w_mmio_hit  = !w_ram_hit && (ALUResult[31:12] == MMIO_BASE[31:12]);
    assign w_mmio_off  = w_word_addr[11:0];
    assign w_mmio_wr   = MemWrite && w_mmio_hit;
    assign w_err_store = MemWrite && !w_ram_hit && !w_mmio_hit;
    // STATUS lives in lane 0, so its W1C bits need that lane enabled.
    assign w_err_clr   = w_mmio_wr && (w_mmio_off == OFF_STATUS) && byte_enable[0]
                         && WriteData[STATUS_ERR_BIT];

    // ----------------------------------------------------------------- timer
    logic [31:0] w_mtime_lo;
    logic [31:0] w_mtime_hi;
    logic [63:0] w_mtimecmp;
    logic        w_irq;

`ifdef DMEM_TIMER_EN
    logic w_lo_read;
    logic w_cmp_lo_we;
    logic w_cmp_hi_we;
    logic w_irq_clr;

    assign w_lo_read   = !MemWrite && w_mmio_hit && (w_mmio_off == OFF_MTIME_LO);
    assign w_cmp_lo_we = w_mmio_wr && (w_mmio_off == OFF_MTIMECMP_LO);
    assign w_cmp_hi_we = w_mmio_wr && (w_mmio_off == OFF_MTIMECMP_HI);
    assign w_irq_clr   = w_mmio_wr && (w_mmio_off == OFF_STATUS) && byte_enable[0]
                         && WriteData[STATUS_IRQ_BIT];

    dmem_timer u_timer (
        .clk               (clk),
        .rst               (rst),
        .i_lo_read         (w_lo_read),
        .i_cmp_lo_we       (w_cmp_lo_we),
        .i_cmp_hi_we       (w_cmp_hi_we),
        .i_irq_clr         (w_irq_clr),
        .i_wdata           (WriteData),
        .i_be              (byte_enable),
        .o_mtime_lo        (w_mtime_lo),
        .o_mtime_hi_shadow (w_mtime_hi),
        .o_mtimecmp        (w_mtimecmp),
        .o_irq             (w_irq)
    );
`else
    assign w_mtime_lo = 32'h0;
    assign w_mtime_hi = 32'h0;
    assign w_mtimecmp = 64'h0;
    assign w_irq      = 1'b0;
`endif

    assign timer_irq = w_irq;

    // ------------------------------------------------------------------- RAM
    logic [31:0] r_ram [DEPTH_WORDS];

    // NOTE: RAM contents are deliberately not reset; rst only gates writes so
    // the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && MemWrite && w_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_enable[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------- MMIO registers
    logic [7:0]  r_gpio;
    logic        r_bus_err;
    logic [31:0] r_erraddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio    <= 8'h0;
            r_bus_err <= 1'b0;
            r_erraddr <= 32'h0;
        end else begin
            if (w_mmio_wr && (w_mmio_off == OFF_GPIO) && byte_enable[0]) begin
                r_gpio <= WriteData[7:0];
            end

            // The first error address is held until software clears the flag;
            // a new error arriving with the clear starts a fresh capture.
            if (w_err_store) begin
                r_bus_err <= 1'b1;
                if (!r_bus_err || w_err_clr) begin
                    r_erraddr <= ALUResult;
                end
            end else if (w_err_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign gpio_out = r_gpio;
    assign bus_err  = r_bus_err;

    // ------------------------------------------------------------- read path
    logic [31:0] w_status;

    always_comb begin
        w_status                 = 32'h0;
        w_status[STATUS_IRQ_BIT] = w_irq;
        w_status[STATUS_ERR_BIT] = r_bus_err;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives ReadData and no
        // latch is inferred.
        ReadData = 32'h0;
        if (w_ram_hit) begin
            ReadData = r_ram[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_mmio_off)
                OFF_MTIME_LO:    ReadData = w_mtime_lo;
                OFF_MTIME_HI:    ReadData = w_mtime_hi;
                OFF_MTIMECMP_LO: ReadData = w_mtimecmp[31:0];
                OFF_MTIMECMP_HI: ReadData = w_mtimecmp[63:32];
                OFF_STATUS:      ReadData = w_status;
                OFF_GPIO:        ReadData = {24'h0, r_gpio};
                OFF_ERRADDR:     ReadData = r_erraddr;
                default:         ReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_responder
// Self-checking bench for dmem_bus_responder. Timer expectations follow the
// DMEM_TIMER_EN build option: with it undefined, timer registers and
// timer_irq are expected to read 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_bus_responder;

    localparam logic [31:0] RB = 32'h2000_0000;
    localparam logic [31:0] MB = 32'h4000_0000;
`ifdef DMEM_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [3:0]  byte_enable;
    logic [31:0] ReadData;
    logic        timer_irq;
    logic [7:0]  gpio_out;
    logic        bus_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam int N_VECS = 26;
    vec_t vecs [N_VECS];

    dmem_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .MemWrite    (MemWrite),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .byte_enable (byte_enable),
        .ReadData    (ReadData),
        .timer_irq   (timer_irq),
        .gpio_out    (gpio_out),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 32'h%08h, expected 32'h%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, compare the combinational load
    // data 1 ns later, then step past the rising edge so registered outputs
    // reflect this cycle on return.
    task automatic bus_cycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic chk, input logic [31:0] exp,
                             input string name);
        logic [31:0] e;
        @(negedge clk);
        MemWrite    = we;
        ALUResult   = addr;
        WriteData   = wdata;
        byte_enable = be;
        if (chk) exp_q.push_back(exp);
        #1;
        if (chk) begin
            e = exp_q.pop_front();
            check(name, ReadData, e);
        end
        @(posedge clk);
        #1;
        MemWrite    = 1'b0;
        byte_enable = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus_cycle(1'b0, addr, 32'h0, 4'b0000, 1'b1, exp, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_cycle(1'b1, addr, data, be, 1'b0, 32'h0, "wr");
    endtask

    // Reset released 1 ns after a rising edge: mtime is 0 on release and
    // reads k-1 during the k-th following bus_cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        MemWrite    = 1'b0;
        ALUResult   = 32'h0;
        WriteData   = 32'h0;
        byte_enable = 4'b0000;

        vecs[0]  = '{1'b1, RB + 32'h8,   32'h0000_0000, 4'b1111, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, RB + 32'h8,   32'h0,         4'b0000, 1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b1, RB + 32'h8,   32'hAABB_CCDD, 4'b0101, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, RB + 32'h8,   32'h0,         4'b0000, 1'b1, 32'h00BB_00DD};
        vecs[4]  = '{1'b0, RB + 32'hB,   32'h0,         4'b0000, 1'b1, 32'h00BB_00DD};
        vecs[5]  = '{1'b1, RB + 32'h8,   32'h1122_3344, 4'b0000, 1'b1, 32'h00BB_00DD};
        vecs[6]  = '{1'b0, RB + 32'h8,   32'h0,         4'b0000, 1'b1, 32'h00BB_00DD};
        vecs[7]  = '{1'b1, RB + 32'hFFC, 32'h1234_5678, 4'b1111, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, RB + 32'hFFC, 32'h0,         4'b0000, 1'b1, 32'h1234_5678};
        vecs[9]  = '{1'b0, RB + 32'h1000, 32'h0,        4'b0000, 1'b1, 32'h0};
        vecs[10] = '{1'b0, RB - 32'h4,   32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[11] = '{1'b1, MB + 32'h14,  32'h0000_00A5, 4'b0001, 1'b0, 32'h0};
        vecs[12] = '{1'b0, MB + 32'h14,  32'h0,         4'b0000, 1'b1, 32'h0000_00A5};
        vecs[13] = '{1'b1, MB + 32'h14,  32'h0000_003C, 4'b1110, 1'b1, 32'h0000_00A5};
        vecs[14] = '{1'b0, MB + 32'h14,  32'h0,         4'b0000, 1'b1, 32'h0000_00A5};
        vecs[15] = '{1'b1, MB + 32'h20,  32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0};
        vecs[16] = '{1'b0, MB + 32'h20,  32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[17] = '{1'b0, MB + 32'h18,  32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[18] = '{1'b0, MB + 32'h10,  32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[19] = '{1'b0, MB + 32'h08,  32'h0,         4'b0000, 1'b1,
                     TIMER_ON ? 32'hFFFF_FFFF : 32'h0};
        vecs[20] = '{1'b1, MB + 32'h0C,  32'h1234_5678, 4'b0011, 1'b0, 32'h0};
        vecs[21] = '{1'b0, MB + 32'h0C,  32'h0,         4'b0000, 1'b1,
                     TIMER_ON ? 32'hFFFF_5678 : 32'h0};
        vecs[22] = '{1'b1, MB + 32'h00,  32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0};
        vecs[23] = '{1'b0, MB + 32'h04,  32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[24] = '{1'b0, MB + 32'hFFC, 32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[25] = '{1'b0, 32'h5000_0000, 32'h0,        4'b0000, 1'b1, 32'h0};

        // ---- reset state
        @(posedge clk);
        #1;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_timer_irq", 32'(timer_irq), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        rst = 1'b0;

        // ---- table-driven RAM / MMIO vectors
        for (int i = 0; i < N_VECS; i++) begin
            bus_cycle(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                      vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("tbl_gpio_out", 32'(gpio_out), 32'h0000_00A5);
        check("tbl_bus_err", 32'(bus_err), 32'h0);

        // ---- unmapped stores, first error held, W1C clear
        do_reset();
        bus_cycle(1'b1, 32'h0000_0100, 32'h1111_1111, 4'b1111, 1'b1, 32'h0, "err_rd_unmapped");
        check("err_set", 32'(bus_err), 32'h1);
        wr(32'h0000_0200, 32'h2222_2222, 4'b1111);
        check("err_still_set", 32'(bus_err), 32'h1);
        rd(MB + 32'h18, 32'h0000_0100, "err_addr_first");
        rd(MB + 32'h10, 32'h0000_0002, "err_status");
        wr(MB + 32'h10, 32'h0000_0002, 4'b1111);
        check("err_cleared", 32'(bus_err), 32'h0);
        rd(32'h0000_0500, 32'h0, "err_unmapped_load");
        check("err_load_no_set", 32'(bus_err), 32'h0);
        wr(32'h0000_0303, 32'h0, 4'b1111);
        check("err_reset_again", 32'(bus_err), 32'h1);
        rd(MB + 32'h18, 32'h0000_0303, "err_addr_recapture");

        // ---- timer compare and W1C
        do_reset();
        wr(MB + 32'h08, 32'd20, 4'b1111);
        wr(MB + 32'h0C, 32'd0, 4'b1111);
        for (int k = 3; k <= 24; k++) begin
            rd(MB + 32'h00, TIMER_ON ? 32'(k - 1) : 32'h0, $sformatf("mtime_lo_c%0d", k));
            check($sformatf("irq_c%0d", k), 32'(timer_irq),
                  (TIMER_ON && k >= 21) ? 32'h1 : 32'h0);
        end
        wr(MB + 32'h10, 32'h0000_0001, 4'b1111);
        check("irq_w1c_low", 32'(timer_irq), 32'h0);
        rd(MB + 32'h10, 32'h0, "status_after_w1c");
        check("irq_reassert", 32'(timer_irq), TIMER_ON ? 32'h1 : 32'h0);
        rd(MB + 32'h10, TIMER_ON ? 32'h1 : 32'h0, "status_irq_bit");

        // ---- HI shadow across a low-word carry
`ifdef DMEM_TIMER_EN
        @(negedge clk);
        force dut.u_timer.r_mtime = 64'h0000_0007_FFFF_FFFE;
        release dut.u_timer.r_mtime;
`endif
        rd(MB + 32'h00, TIMER_ON ? 32'hFFFF_FFFF : 32'h0, "shadow_lo1");
        rd(MB + 32'h04, TIMER_ON ? 32'h0000_0007 : 32'h0, "shadow_hi1");
        rd(MB + 32'h00, TIMER_ON ? 32'h0000_0001 : 32'h0, "shadow_lo2");
        rd(MB + 32'h04, TIMER_ON ? 32'h0000_0008 : 32'h0, "shadow_hi2");

        // ---- asynchronous reset mid-count, RAM preserved
        wr(MB + 32'h14, 32'h0000_005A, 4'b0001);
        wr(RB + 32'h20, 32'hCAFE_F00D, 4'b1111);
        check("pre_rst_gpio", 32'(gpio_out), 32'h0000_005A);
        check("pre_rst_irq", 32'(timer_irq), TIMER_ON ? 32'h1 : 32'h0);
        @(negedge clk);
        MemWrite  = 1'b0;
        ALUResult = MB;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gpio", 32'(gpio_out), 32'h0);
        check("async_rst_irq", 32'(timer_irq), 32'h0);
        exp_q.push_back(32'h0);
        check("async_rst_mtime", ReadData, exp_q.pop_front());
        MemWrite    = 1'b1;
        ALUResult   = RB + 32'h20;
        WriteData   = 32'h0;
        byte_enable = 4'b1111;
        @(posedge clk);
        #1;
        ALUResult = MB + 32'h14;
        WriteData = 32'h0000_00FF;
        @(posedge clk);
        #1;
        MemWrite    = 1'b0;
        byte_enable = 4'b0000;
        check("in_rst_gpio", 32'(gpio_out), 32'h0);
        rst = 1'b0;
        rd(RB + 32'h20, 32'hCAFE_F00D, "ram_kept_over_rst");
        rd(MB + 32'h08, TIMER_ON ? 32'hFFFF_FFFF : 32'h0, "rst_mtimecmp_lo");
        rd(MB + 32'h0C, TIMER_ON ? 32'hFFFF_FFFF : 32'h0, "rst_mtimecmp_hi");
        check("post_rst_gpio", 32'(gpio_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
